ldd_trig_sched: RTL

- Capture-path shot scheduler. It sits directly upstream of the LDD capture/output driver.
- Issues a programmed burst of `cap_trig` pulses at a fixed period, each carrying a stable `cap_plus` / `cap_wdis` payload.
- Gates every shot on the driver's `capr_rdy` handshake and flags late shots.
- Runs only while `cap_mode` = 1. The driver holds its capture path in reset otherwise.

---
 rtl/ldd_pkg.sv | 22 ++
 rtl/ldd_period_cnt.sv | 48 ++++
 rtl/ldd_trig_sched.sv | 179 +++++++++++++++++
 3 files changed

// File: rtl/ldd_pkg.sv
// Shared definitions for the LDD capture-path blocks.
//   state_e      : shot scheduler FSM states
//   DEF_*        : default widths (width select, payload, period, shot count)
//   MIN_PER      : shortest legal shot period in clk200 cycles
package ldd_pkg;

  localparam int DEF_TOP0_0 = 3;
  localparam int DEF_LDD0_0 = 32;
  localparam int DEF_PER_W  = 24;
  localparam int DEF_CNT_W  = 16;

  localparam int MIN_PER = 2;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_WAIT_RDY = 3'd1,
    ST_FIRE     = 3'd2,
    ST_GAP      = 3'd3,
    ST_FIN      = 3'd4
  } state_e;

endpackage

// File: rtl/ldd_period_cnt.sv
// Loadable down-counter with a one-cycle expire strobe.
//   clk, rst  : clock, synchronous active-high reset
//   load      : load load_val and start counting (wins over decrement)
//   clear     : stop counting without expiring (wins over load)
//   load_val  : number of idle cycles before expire is raised
//   expire    : high for one cycle when the running count reaches zero
// With load_val = N the strobe is high in the (N+1)th cycle after the load edge.
module ldd_period_cnt #(
  parameter int W = 24
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic         clear,
  input  logic [W-1:0] load_val,
  output logic         expire
);

  logic [W-1:0] cnt_d, cnt_q;
  logic         act_d, act_q;

  always_comb begin
    cnt_d = cnt_q;
    act_d = act_q;
    if (clear) begin
      act_d = 1'b0;
    end else if (load) begin
      cnt_d = load_val;
      act_d = 1'b1;
    end else if (act_q) begin
      if (cnt_q == '0) act_d = 1'b0;
      else             cnt_d = cnt_q - W'(1);
    end
  end

  assign expire = act_q && (cnt_q == '0);

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
      act_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      act_q <= act_d;
    end
  end

endmodule

// File: rtl/ldd_trig_sched.sv
// Capture-path shot scheduler: fires a programmed burst of cap_trig pulses
// at a fixed period, gated by the driver's capr_rdy.
//   clk200, rst            : clock, synchronous active-high reset
//   cap_mode               : capture enable; dropping it aborts the burst
//   cfg_start / cfg_stop   : one-cycle start / abort requests
//   cfg_wdis, cfg_plus     : payload, latched at start
//   cfg_period, cfg_count  : shot period (clamped to >= 2), shots (0 = endless)
//   capr_rdy               : driver ready for the next trigger
//   cap_trig               : one-cycle shot strobe
//   cap_wdis, cap_plus     : latched payload, stable while busy
//   busy, done, aborted    : burst status; aborted qualifies done
//   shot_cnt, miss_err     : shots fired, sticky late-shot flag
//   state_dbg              : current FSM state
// Handshake: a shot is only launched from WAIT_RDY or at GAP expiry, and only
// when capr_rdy is 1 in that cycle; capr_rdy is ignored everywhere else.
// Timing: FIRE lasts one cycle, GAP lasts P-1 cycles, so trigs are P apart.
module ldd_trig_sched
  import ldd_pkg::*;
#(
  parameter int TOP0_0 = DEF_TOP0_0,
  parameter int LDD0_0 = DEF_LDD0_0,
  parameter int PER_W  = DEF_PER_W,
  parameter int CNT_W  = DEF_CNT_W
) (
  input  logic              clk200,
  input  logic              rst,
  input  logic              cap_mode,
  input  logic              cfg_start,
  input  logic              cfg_stop,
  input  logic [TOP0_0-1:0] cfg_wdis,
  input  logic [LDD0_0-1:0] cfg_plus,
  input  logic [PER_W-1:0]  cfg_period,
  input  logic [CNT_W-1:0]  cfg_count,
  input  logic              capr_rdy,
  output logic              cap_trig,
  output logic [TOP0_0-1:0] cap_wdis,
  output logic [LDD0_0-1:0] cap_plus,
  output logic              busy,
  output logic              done,
  output logic              aborted,
  output logic [CNT_W-1:0]  shot_cnt,
  output logic              miss_err,
  output state_e            state_dbg
);

  state_e            state_d, state_q;
  logic              trig_d, trig_q;
  logic [TOP0_0-1:0] wdis_d, wdis_q;
  logic [LDD0_0-1:0] plus_d, plus_q;
  logic              busy_d, busy_q;
  logic              done_d, done_q;
  logic              aborted_d, aborted_q;
  logic [CNT_W-1:0]  shot_cnt_d, shot_cnt_q;
  logic              miss_err_d, miss_err_q;
  logic [PER_W-1:0]  per_d, per_q;
  logic [CNT_W-1:0]  lim_d, lim_q;

  logic abort;
  logic per_load;
  logic per_expire;

  // Abort is checked before the state case so it beats FIRE and completion.
  assign abort = (state_q != ST_IDLE) && (cfg_stop || !cap_mode);

  always_comb begin
    state_d    = state_q;
    trig_d     = 1'b0;
    done_d     = 1'b0;
    aborted_d  = 1'b0;
    busy_d     = busy_q;
    wdis_d     = wdis_q;
    plus_d     = plus_q;
    per_d      = per_q;
    lim_d      = lim_q;
    shot_cnt_d = shot_cnt_q;
    miss_err_d = miss_err_q;
    per_load   = 1'b0;

    if (abort) begin
      state_d   = ST_IDLE;
      done_d    = 1'b1;
      aborted_d = 1'b1;
      busy_d    = 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (cfg_start && cap_mode && !cfg_stop) begin
            wdis_d     = cfg_wdis;
            plus_d     = cfg_plus;
            per_d      = (cfg_period < PER_W'(MIN_PER)) ? PER_W'(MIN_PER) : cfg_period;
            lim_d      = cfg_count;
            shot_cnt_d = '0;
            miss_err_d = 1'b0;
            busy_d     = 1'b1;
            state_d    = ST_WAIT_RDY;
          end
        end
        ST_WAIT_RDY: begin
          if (capr_rdy) state_d = ST_FIRE;
        end
        ST_FIRE: begin
          trig_d     = 1'b1;
          shot_cnt_d = shot_cnt_q + CNT_W'(1);
          per_load   = 1'b1;
          state_d    = ST_GAP;
        end
        ST_GAP: begin
          if (per_expire) begin
            if ((lim_q != '0) && (shot_cnt_q == lim_q)) begin
              state_d = ST_FIN;
            end else if (capr_rdy) begin
              state_d = ST_FIRE;
            end else begin
              miss_err_d = 1'b1;
              state_d    = ST_WAIT_RDY;
            end
          end
        end
        ST_FIN: begin
          done_d  = 1'b1;
          busy_d  = 1'b0;
          state_d = ST_IDLE;
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // GAP must last P-1 cycles: the counter idles P-2 cycles, then expires.
  ldd_period_cnt #(
    .W (PER_W)
  ) u_period_cnt (
    .clk      (clk200),
    .rst      (rst),
    .load     (per_load),
    .clear    (abort),
    .load_val (per_q - PER_W'(MIN_PER)),
    .expire   (per_expire)
  );

  always_ff @(posedge clk200) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      trig_q     <= 1'b0;
      wdis_q     <= '0;
      plus_q     <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      aborted_q  <= 1'b0;
      shot_cnt_q <= '0;
      miss_err_q <= 1'b0;
      per_q      <= '0;
      lim_q      <= '0;
    end else begin
      state_q    <= state_d;
      trig_q     <= trig_d;
      wdis_q     <= wdis_d;
      plus_q     <= plus_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      aborted_q  <= aborted_d;
      shot_cnt_q <= shot_cnt_d;
      miss_err_q <= miss_err_d;
      per_q      <= per_d;
      lim_q      <= lim_d;
    end
  end

  assign cap_trig  = trig_q;
  assign cap_wdis  = wdis_q;
  assign cap_plus  = plus_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign aborted   = aborted_q;
  assign shot_cnt  = shot_cnt_q;
  assign miss_err  = miss_err_q;
  assign state_dbg = state_q;

endmodule
